seg_frame_arbiter: RTL and testbench

Shares the 8-digit seven-segment display between several frame producers: error countdown, mode banner, bonus cycle readout and matrix viewer. Each producer presents a complete 8-glyph frame and a level request. The block grants one owner at a time and forwards that owner's frame to the scan driver. Requester 0 is the urgent channel (calculation-error countdown) and preempts all others; the remaining requesters rotate round-robin after a minimum dwell time, with optional per-requester blinking.

---
 rtl/seg_frame_arbiter_if.sv | 22 ++
 rtl/seg_frame_arbiter.sv | 131 +++++++++++++
 tb/tb_seg_frame_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg_frame_arbiter_if.sv
// rtl/seg_frame_arbiter_if.sv - requester and scan-driver bundle for the seven-segment frame arbiter
interface seg_frame_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [64*NUM_REQ-1:0] frame_in;
  logic [NUM_REQ-1:0]    blink_in;
  logic [NUM_REQ-1:0]    grant;
  logic [63:0]           frame_out;
  logic                  frame_valid;
  logic                  switch_pulse;

  modport master (
    output req, frame_in, blink_in,
    input  grant, frame_out, frame_valid, switch_pulse
  );

  modport slave (
    input  req, frame_in, blink_in,
    output grant, frame_out, frame_valid, switch_pulse
  );
endinterface

// File: rtl/seg_frame_arbiter.sv
// rtl/seg_frame_arbiter.sv - grants the 8-digit display to one frame producer; index 0 preempts, others rotate after a dwell
// Optional per-owner blinking is built when SEG_ARB_BLINK_EN is defined.
module seg_frame_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int BLINK_HALF   = 25_000_000
) (
  input logic              clk,
  input logic              rst,
  seg_frame_arbiter_if.slave bus
);
  localparam int          IW    = $clog2(NUM_REQ);
  localparam int          DW    = $clog2(DWELL_CYCLES + 1);
  localparam logic [63:0] BLANK = {8{8'hFF}};

  typedef enum logic [1:0] {IDLE, SHOW, FREE} state_t;

  state_t             state;
  logic [IW-1:0]      owner;
  logic [IW-1:0]      last;
  logic [IW-1:0]      nxt;
  logic [IW-1:0]      rr_idx;
  logic [DW-1:0]      dwell;
  logic [NUM_REQ-1:0] pool;
  logic [NUM_REQ-1:0] upper;
  logic               rr_any;
  logic               take;
  logic               go_idle;
  logic               hide;

  // Round-robin: lowest pending index above last, otherwise lowest pending overall.
  always_comb begin
    pool    = bus.req & ~(NUM_REQ'(1) << owner);
    pool[0] = 1'b0;
    upper   = '0;
    for (int i = 1; i < NUM_REQ; i++) upper[i] = pool[i] && (i > int'(last));
    rr_any = |pool;
    rr_idx = '0;
    for (int i = NUM_REQ - 1; i >= 1; i--) if (pool[i]) rr_idx = IW'(i);
    for (int i = NUM_REQ - 1; i >= 1; i--) if (upper[i]) rr_idx = IW'(i);
  end

  always_comb begin
    take    = 1'b0;
    go_idle = 1'b0;
    nxt     = owner;
    if (state == IDLE || !bus.req[owner]) begin
      if (bus.req[0]) begin
        take = 1'b1;
        nxt  = '0;
      end else if (rr_any) begin
        take = 1'b1;
        nxt  = rr_idx;
      end else if (state != IDLE) begin
        go_idle = 1'b1;
      end
    end else if (owner != '0 && bus.req[0]) begin
      take = 1'b1;
      nxt  = '0;
    end else if (state == FREE && owner != '0 && rr_any) begin
      take = 1'b1;
      nxt  = rr_idx;
    end
  end

`ifdef SEG_ARB_BLINK_EN
  localparam int BW = $clog2(BLINK_HALF + 1);
  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic          wrap;

  // hide looks at the phase the next output cycle will be in
  assign wrap = int'(blink_cnt) == BLINK_HALF - 1;
  assign hide = bus.blink_in[owner] && (phase ^ wrap);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (take || go_idle || state == IDLE) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      blink_cnt <= wrap ? '0 : blink_cnt + 1'b1;
      phase     <= phase ^ wrap;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = ^bus.blink_in;
  assign hide         = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      owner            <= '0;
      last             <= '0;
      dwell            <= '0;
      bus.grant        <= '0;
      bus.frame_out    <= BLANK;
      bus.frame_valid  <= 1'b0;
      bus.switch_pulse <= 1'b0;
    end else begin
      bus.switch_pulse <= take || go_idle;
      if (go_idle) begin
        state           <= IDLE;
        owner           <= '0;
        dwell           <= '0;
        bus.grant       <= '0;
        bus.frame_valid <= 1'b0;
        bus.frame_out   <= BLANK;
      end else if (take) begin
        state           <= (DWELL_CYCLES <= 1) ? FREE : SHOW;
        owner           <= nxt;
        dwell           <= '0;
        if (nxt != '0) last <= nxt;
        bus.grant       <= NUM_REQ'(1) << nxt;
        bus.frame_valid <= 1'b1;
        bus.frame_out   <= bus.frame_in[64*int'(nxt) +: 64];
      end else if (state != IDLE) begin
        // FREE is entered on the edge where dwell becomes DWELL_CYCLES-1
        if (state == SHOW) begin
          dwell <= dwell + 1'b1;
          if (int'(dwell) + 2 >= DWELL_CYCLES) state <= FREE;
        end
        bus.frame_out <= hide ? BLANK : bus.frame_in[64*int'(owner) +: 64];
      end
    end
  end
endmodule

// File: tb/tb_seg_frame_arbiter.sv
// tb/tb_seg_frame_arbiter.sv - directed bench with a cycle-level reference model for seg_frame_arbiter
module tb_seg_frame_arbiter;
  localparam int          N     = 4;
  localparam int          DWELL = 8;
  localparam int          BH    = 4;
  localparam logic [63:0] BLANK = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef SEG_ARB_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  localparam logic [63:0] F0  = 64'h86AF_AFC0_AFFF_FFFF;
  localparam logic [63:0] F1  = 64'h00C0_F9A4_B099_9282;
  localparam logic [63:0] F2  = 64'hC7C1_C0A4_F9A4_B099;
  localparam logic [63:0] F3  = 64'h1122_3344_5566_7788;
  localparam logic [63:0] F3B = 64'hA1B2_C3D4_E5F6_0718;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_frame_arbiter_if #(.NUM_REQ(N)) bus ();

  seg_frame_arbiter #(
    .NUM_REQ(N), .DWELL_CYCLES(DWELL), .BLINK_HALF(BH)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: owner as an integer (-1 idle), age = cycles since the grant edge.
  int          m_owner = -1;
  int          m_last  = 0;
  int          m_age   = 0;
  logic        m_pulse = 1'b0;
  logic [63:0] m_frame = BLANK;
  int          m_next;
  int          m_next_age;

  function automatic int rr_pick(input logic [N-1:0] pool, input int last);
    for (int k = 1; k < N; k++) begin
      int c;
      c = ((last + k - 1) % (N - 1)) + 1;
      if (pool[c]) return c;
    end
    return -1;
  endfunction

  function automatic int next_owner(input int own, input int age, input logic [N-1:0] r, input int last);
    logic [N-1:0] oth;
    int w;
    oth = r;
    oth[0] = 1'b0;
    if (own >= 0) oth[own] = 1'b0;
    w = rr_pick(oth, last);
    if (own < 0 || !r[own]) return r[0] ? 0 : w;
    if (own == 0 || r[0]) return 0;
    if (age >= DWELL - 1 && w >= 0) return w;
    return own;
  endfunction

  function automatic logic [63:0] exp_frame(input int own, input int age, input logic [N-1:0] blk,
                                            input logic [64*N-1:0] frames);
    if (own < 0) return BLANK;
    if (BLINK_EN && blk[own] && ((age / BH) % 2 == 1)) return BLANK;
    return frames[64*own +: 64];
  endfunction

  always_comb begin
    m_next     = next_owner(m_owner, m_age, bus.req, m_last);
    m_next_age = (m_next != m_owner) ? 0 : m_age + 1;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner <= -1;
      m_last  <= 0;
      m_age   <= 0;
      m_pulse <= 1'b0;
      m_frame <= BLANK;
    end else begin
      m_owner <= m_next;
      m_age   <= m_next_age;
      m_pulse <= (m_next != m_owner);
      if (m_next > 0) m_last <= m_next;
      m_frame <= exp_frame(m_next, m_next_age, bus.blink_in, bus.frame_in);
    end
  end

  always @(negedge clk) begin
    chk("grant", 64'(bus.grant), (m_owner < 0) ? 64'd0 : (64'd1 << m_owner));
    chk("frame_valid", 64'(bus.frame_valid), (m_owner >= 0) ? 64'd1 : 64'd0);
    chk("frame_out", bus.frame_out, m_frame);
    chk("switch_pulse", 64'(bus.switch_pulse), 64'(m_pulse));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  logic [N-1:0] cur;
  logic [N-1:0] exp_seq [3];
  int           exp_idx [3];
  int           n;

  initial begin
    bus.req      = 4'b1111;
    bus.blink_in = '0;
    bus.frame_in = {F3, F2, F1, F0};

    // reset values
    step(2);
    chk("rst_grant", 64'(bus.grant), 64'h0);
    chk("rst_frame", bus.frame_out, BLANK);
    chk("rst_valid", 64'(bus.frame_valid), 64'h0);
    bus.req = 4'b1110;
    rst     = 1'b0;
    step(1);
    chk("first_grant", 64'(bus.grant), 64'h2);
    chk("first_pulse", 64'(bus.switch_pulse), 64'h1);
    chk("first_frame", bus.frame_out, F1);

    // rotation, each owner held exactly DWELL cycles
    exp_seq = '{4'b0100, 4'b1000, 4'b0010};
    exp_idx = '{2, 3, 1};
    for (int k = 0; k < 3; k++) begin
      cur = bus.grant;
      n   = 0;
      do begin
        step(1);
        n++;
      end while (bus.grant == cur && n < 30);
      chk("rot_grant", 64'(bus.grant), 64'(exp_seq[k]));
      chk("rot_hold", 64'(n), 64'd8);
      chk("rot_frame", bus.frame_out, bus.frame_in[64*exp_idx[k] +: 64]);
    end

    // preemption of owner 2 at dwell 3
    n = 0;
    while (bus.grant != 4'b0100 && n < 30) begin
      step(1);
      n++;
    end
    step(3);
    bus.req = 4'b1111;
    step(1);
    chk("preempt_grant", 64'(bus.grant), 64'h1);
    chk("preempt_frame", bus.frame_out, F0);
    step(40);
    chk("urgent_hold", 64'(bus.grant), 64'h1);
    bus.req = 4'b1000;
    step(1);
    chk("after_urgent", 64'(bus.grant), 64'h8);

    // live frame update of owner 3
    step(2);
    bus.frame_in[64*3 +: 64] = F3B;
    step(1);
    chk("live_frame", bus.frame_out, F3B);
    chk("live_grant", 64'(bus.grant), 64'h8);

    // release to idle, then release racing an urgent rise
    bus.req = 4'b0010;
    step(1);
    chk("handoff_1", 64'(bus.grant), 64'h2);
    bus.req = 4'b0000;
    step(1);
    chk("idle_grant", 64'(bus.grant), 64'h0);
    chk("idle_valid", 64'(bus.frame_valid), 64'h0);
    chk("idle_frame", bus.frame_out, BLANK);
    chk("idle_pulse", 64'(bus.switch_pulse), 64'h1);
    bus.req = 4'b0010;
    step(2);
    bus.req = 4'b0001;
    step(1);
    chk("race_grant", 64'(bus.grant), 64'h1);

    // blink on owner 1
    bus.req      = 4'b0010;
    bus.blink_in = 4'b0010;
    step(1);
    chk("blink_age0", bus.frame_out, F1);
    step(4);
    chk("blink_age4", bus.frame_out, BLINK_EN ? BLANK : F1);
    step(4);
    chk("blink_age8", bus.frame_out, F1);
    step(5);
    chk("blink_age13", bus.frame_out, BLINK_EN ? BLANK : F1);
    chk("blink_valid", 64'(bus.frame_valid), 64'h1);

    // asynchronous reset mid-operation clears the RR pointer too
    rst = 1'b1;
    #1;
    chk("async_grant", 64'(bus.grant), 64'h0);
    chk("async_frame", bus.frame_out, BLANK);
    chk("async_valid", 64'(bus.frame_valid), 64'h0);
    step(1);
    bus.req      = 4'b1110;
    bus.blink_in = '0;
    rst          = 1'b0;
    step(1);
    chk("post_rst_grant", 64'(bus.grant), 64'h2);
    step(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
